// File: rtl/uart_rx.sv
// 8N1 serial receiver with a runtime bit period (baud_cnt+1 clocks), mid-bit sampling and sticky rdy/frm_err/overrun flags.
// Optional build macro: UART_RX_MAJORITY_EN (three-sample majority vote per bit).
module uart_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [12:0] baud_cnt,
  input  logic        clr_rdy,
  output logic [7:0]  rx_data,
  output logic        rdy,
  output logic        frm_err,
  output logic        overrun,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_ff1, rx_s, rx_prev;
  logic        fall;
  logic [12:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        sample_evt;
  logic        bit_val;
  logic        start_frame, shift_en, frame_end;
  logic        done, stop_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_s    <= rx_ff1;
      rx_prev <= rx_s;
    end
  end

  assign fall       = rx_prev & ~rx_s;
  assign sample_evt = (state != IDLE) && (cnt == 13'd0);

  // Counter holds in IDLE; it only matters once a start edge loads the half period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 13'd0;
    end else if (state == IDLE) begin
      if (fall) cnt <= baud_cnt >> 1;
    end else if (cnt == 13'd0) begin
      cnt <= baud_cnt;
    end else begin
      cnt <= cnt - 13'd1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp2, samp1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp2 <= 1'b1;
      samp1 <= 1'b1;
    end else if (state != IDLE) begin
      if (cnt == 13'd2) samp2 <= rx_s;
      if (cnt == 13'd1) samp1 <= rx_s;
    end
  end

  assign bit_val = (samp2 & samp1) | (samp2 & rx_s) | (samp1 & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (sample_evt) state_nxt = bit_val ? IDLE : DATA;
      DATA:  if (sample_evt && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:  if (sample_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_frame = (state == IDLE) && fall;
    shift_en    = (state == DATA) && sample_evt;
    frame_end   = (state == STOP) && sample_evt;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      done     <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      if (start_frame)   bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)  shift    <= {bit_val, shift[7:1]};
      if (frame_end) stop_bit <= bit_val;
      done <= frame_end;
    end
  end

  // Host handshake: rdy rises when a good byte lands in rx_data and stays up until a
  // one-cycle clr_rdy; a frame completing in the same cycle as clr_rdy wins for its own flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else if (done && stop_bit) begin
      rx_data <= shift;
      rdy     <= 1'b1;
      overrun <= clr_rdy ? 1'b0 : (overrun | rdy);
      frm_err <= clr_rdy ? 1'b0 : frm_err;
    end else if (done) begin
      frm_err <= 1'b1;
      if (clr_rdy) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [12:0] baud_cnt = 13'd433;
  logic        clr_rdy = 1'b0;
  logic [7:0]  rx_data;
  logic        rdy, frm_err, overrun;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Entry: {completion cycle[40:9], byte[8:1], stop bit ok[0]}
  logic [40:0] exp_q[$];
  logic [7:0]  m_data = 8'h00;
  logic        m_rdy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .baud_cnt  (baud_cnt),
    .clr_rdy   (clr_rdy),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frm_err   (frm_err),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Cycles from the RX start edge to the edge where the outputs update.
  function automatic int done_offset(input int b);
    return 3 + (b >> 1) + 1 + 9 * (b + 1) + 1;
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_at,
                            input logic [7:0] exp_data);
    int per;
    int bit_idx;
    logic lvl;
    logic [31:0] due;
    per = int'(baud_cnt) + 1;
    due = 32'(cyc + done_offset(int'(baud_cnt)));
    exp_q.push_back({due, exp_data, stop});
    for (int j = 0; j < 10 * per; j++) begin
      bit_idx = j / per;
      if (bit_idx == 0)      lvl = 1'b0;
      else if (bit_idx == 9) lvl = stop;
      else                   lvl = data[bit_idx - 1];
      if (j == glitch_at) lvl = 1'b1;
      RX = lvl;
      tick();
    end
    RX = 1'b1;
  endtask

  task automatic clr_pulse();
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
  endtask

  task automatic clr_at(input int target);
    while (cyc < target - 1) tick();
    clr_pulse();
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic r,
                               input logic f, input logic o);
    check({tag, "_data"}, int'(rx_data), int'(d));
    check({tag, "_rdy"},  int'(rdy),     int'(r));
    check({tag, "_frm"},  int'(frm_err), int'(f));
    check({tag, "_ovr"},  int'(overrun), int'(o));
  endtask

  // Monitor: applies expected frame completions and clr_rdy to the output model each edge.
  initial begin : monitor
    logic [40:0] e;
    logic [10:0] act, expv, prev_act;
    logic        evt, clr_s;
    prev_act = '0;
    forever begin
      @(posedge clk);
      cyc++;
      evt   = 1'b0;
      clr_s = clr_rdy;
      if (!rst_n) begin
        m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
      end else if (exp_q.size() != 0 && int'(exp_q[0][40:9]) == cyc) begin
        e   = exp_q.pop_front();
        evt = 1'b1;
        if (e[0]) begin
          m_ovr  = clr_s ? 1'b0 : (m_ovr | m_rdy);
          m_frm  = clr_s ? 1'b0 : m_frm;
          m_rdy  = 1'b1;
          m_data = e[8:1];
        end else begin
          m_frm = 1'b1;
          if (clr_s) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
          end
        end
      end else if (clr_s) begin
        m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
      end
      act  = {rx_data, rdy, frm_err, overrun};
      expv = {m_data, m_rdy, m_frm, m_ovr};
      if (evt || act != prev_act) begin
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: got data=%h rdy=%b frm=%b ovr=%b expected data=%h rdy=%b frm=%b ovr=%b",
                   cyc, rx_data, rdy, frm_err, overrun, m_data, m_rdy, m_frm, m_ovr);
        end
      end
      prev_act = act;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int c0, lat, n, gap, c1;
    logic [7:0] d;
    logic st;

    baud_cnt = 13'd433;
    wait_cycles(3);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Basic byte with exact latency measurement.
    c0 = cyc;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, -1, 8'hA5);
      begin
        n = 0;
        while (!rdy && n < 6000) begin
          @(negedge clk);
          n++;
        end
        lat = cyc - c0;
      end
    join
    check("a5_latency", lat, 4127);
    check_outputs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);

    // False start: short low pulse must not produce a frame.
    clr_pulse();
    RX = 1'b0;
    wait_cycles(100);
    RX = 1'b1;
    wait_cycles(600);
    check_outputs("false_start", 8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, 8'h3C);
    check_outputs("after_false", 8'h3C, 1'b1, 1'b0, 1'b0);

    // Framing error keeps rx_data and rdy.
    clr_pulse();
    send_frame(8'h81, 1'b0, -1, 8'h81);
    check_outputs("frm", 8'h3C, 1'b0, 1'b1, 1'b0);
    clr_pulse();
    check("frm_clear", int'(frm_err), 0);

    // Back-to-back at minimum period, overrun then clear-in-same-cycle.
    baud_cnt = 13'd8;
    wait_cycles(4);
    send_frame(8'h11, 1'b1, -1, 8'h11);
    send_frame(8'h22, 1'b1, -1, 8'h22);
    check_outputs("b2b_ovr", 8'h22, 1'b1, 1'b0, 1'b1);
    clr_pulse();
    wait_cycles(4);
    c1 = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1, -1, 8'h11);
        send_frame(8'h22, 1'b1, -1, 8'h22);
      end
      clr_at(c1 + 90 + done_offset(8));
    join
    check_outputs("b2b_clr", 8'h22, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a 0xFF frame.
    baud_cnt = 13'd433;
    wait_cycles(4);
    RX = 1'b0;
    wait_cycles(434);
    RX = 1'b1;
    wait_cycles(3 * 434);
    rst_n = 1'b0;
    #1;
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(8 * 434);
    send_frame(8'h5A, 1'b1, -1, 8'h5A);
    check_outputs("post_reset", 8'h5A, 1'b1, 1'b0, 1'b0);

    // One-clock high glitch aligned to the final sample point of data bit 0.
    clr_pulse();
`ifdef UART_RX_MAJORITY_EN
    d = 8'h00;
`else
    d = 8'h01;
`endif
    send_frame(8'h00, 1'b1, 216 + 433 + 2, d);
    check("glitch_data", int'(rx_data), int'(d));

    // Randomized frames: period, data, stop bit, gaps and host clears.
    for (int i = 0; i < 24; i++) begin
      baud_cnt = 13'($urandom_range(8, 40));
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 9) != 0);
      send_frame(d, st, -1, d);
      gap = $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 1) clr_pulse();
      wait_cycles(gap);
    end

    wait_cycles(500);
    check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
